// File: rtl/phys_free_list.sv
// Physical-register free-list manager: grants two free registers per cycle, reclaims
// registers at retire, and rebuilds the speculative mask from committed state on flush.
// Optional release checking is compiled in with `define FREELIST_CHECK_EN.
`ifndef PHYS_REGS
`define PHYS_REGS 16
`endif

module phys_free_list #(
    parameter int  PHYS_REGS = `PHYS_REGS,
    localparam int RW        = $clog2(PHYS_REGS),
    localparam int CW        = $clog2(PHYS_REGS) + 1,
    localparam int N         = PHYS_REGS - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alloc_req,
    output logic          alloc_grant,
    output logic [RW-1:0] alloc_reg0,
    output logic [RW-1:0] alloc_reg1,
    input  logic          retire_valid,
    input  logic [RW-1:0] retire_new0,
    input  logic [RW-1:0] retire_new1,
    input  logic [RW-1:0] retire_old0,
    input  logic [RW-1:0] retire_old1,
    input  logic          flush,
    output logic [N-1:0]  available_out,
    output logic [CW-1:0] free_count,
    output logic          err
);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_RECOVER} state_t;

    state_t        state_reg, state_next;
    logic          run_active;
    logic [N-1:0]  spec_free_reg, spec_free_next;
    logic [N-1:0]  commit_used_reg, commit_used_next;
    logic [CW-1:0] free_count_reg, free_count_next;
    logic [N-1:0]  new_mask, old_mask, grant_mask;
    logic          found0, found1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_INIT:    state_next = ST_RUN;
            ST_RUN:     state_next = flush ? ST_RECOVER : ST_RUN;
            ST_RECOVER: state_next = flush ? ST_RECOVER : ST_RUN;
            default:    state_next = ST_INIT;
        endcase
    end

    // FSM outputs
    always_comb begin
        run_active = (state_reg == ST_RUN);
    end

    // Two lowest free registers; bit i of the mask is physical register i+1
    always_comb begin
        alloc_reg0 = '0;
        alloc_reg1 = '0;
        grant_mask = '0;
        found0     = 1'b0;
        found1     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (spec_free_reg[i]) begin
                if (!found0) begin
                    alloc_reg0    = RW'(i + 1);
                    grant_mask[i] = 1'b1;
                    found0        = 1'b1;
                end else if (!found1) begin
                    alloc_reg1    = RW'(i + 1);
                    grant_mask[i] = 1'b1;
                    found1        = 1'b1;
                end
            end
        end
    end

    assign alloc_grant = alloc_req && run_active && !flush && (free_count_reg >= CW'(2));

    // Register 0 never matches any mask bit, so retiring it is a no-op
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_retire_dec
            assign new_mask[gi] = retire_valid &&
                                  ((retire_new0 == RW'(gi + 1)) || (retire_new1 == RW'(gi + 1)));
            assign old_mask[gi] = retire_valid &&
                                  ((retire_old0 == RW'(gi + 1)) || (retire_old1 == RW'(gi + 1)));
        end
    endgenerate

    assign commit_used_next = (commit_used_reg | new_mask) & ~old_mask;

    // Released registers are not bypassed to the grant path; they show up next cycle
    always_comb begin
        if (flush) begin
            spec_free_next = ~commit_used_next;
        end else begin
            spec_free_next = (spec_free_reg & ~(alloc_grant ? grant_mask : '0)) | old_mask;
        end
        free_count_next = '0;
        for (int i = 0; i < N; i++) begin
            free_count_next = free_count_next + CW'(spec_free_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_free_reg   <= '1;
            commit_used_reg <= '0;
            free_count_reg  <= CW'(N);
        end else begin
            spec_free_reg   <= spec_free_next;
            commit_used_reg <= commit_used_next;
            free_count_reg  <= free_count_next;
        end
    end

    assign available_out = spec_free_reg;
    assign free_count    = free_count_reg;

`ifdef FREELIST_CHECK_EN
    logic err_reg;
    logic err_hit;

    // Double free against the pre-edge mask, or the same register released twice
    assign err_hit = (|(old_mask & spec_free_reg)) ||
                     (retire_valid && (retire_old0 == retire_old1) && (retire_old0 != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_reg | err_hit;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule
